// File: rtl/rf_led_scanner_pkg.sv
// Shared widths, FSM encoding and byte-lane helper for the register-file LED scanner.
// The register file is 8 x 32; the board shows a 2-bit lane tag plus one byte.
package rf_led_scanner_pkg;

    localparam int RF_IDX_W   = 3;
    localparam int RF_DATA_W  = 32;
    localparam int LED_W      = 10;
    localparam int BYTE_SEL_W = 2;

    typedef enum logic {
        SETTLE = 1'b0,
        SHOW   = 1'b1
    } scan_state_e;

    // Lane 0 is the least significant byte of the word.
    function automatic logic [7:0] select_byte(
        input logic [RF_DATA_W-1:0]  word,
        input logic [BYTE_SEL_W-1:0] sel
    );
        logic [7:0] lane;
        case (sel)
            2'd0:    lane = word[7:0];
            2'd1:    lane = word[15:8];
            2'd2:    lane = word[23:16];
            default: lane = word[31:24];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/rf_led_scanner_sync_edge.sv
// Two-flop synchroniser for asynchronous board inputs. One lane also gets a
// third flop so a rising edge becomes a single-cycle pulse; the rest are level-only.
module sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         edge_d,
    input  logic [W-1:0] lvl_d,
    output logic [W-1:0] lvl_q,
    output logic         rise
);

    logic [W-1:0] lvl_meta;
    logic         edge_meta;
    logic         edge_q;
    logic         edge_last;

    // NOTE: flops use non-blocking assignments so every stage samples the
    // value its predecessor held before this edge; blocking here would
    // collapse the chain into a single flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_meta  <= '0;
            lvl_q     <= '0;
            edge_meta <= 1'b0;
            edge_q    <= 1'b0;
            edge_last <= 1'b0;
        end else begin
            lvl_meta  <= lvl_d;
            lvl_q     <= lvl_meta;
            edge_meta <= edge_d;
            edge_q    <= edge_meta;
            edge_last <= edge_q;
        end
    end

    assign rise = edge_q & ~edge_last;

endmodule

// File: rtl/rf_led_scanner.sv
// Debug client on a spare register-file read port: walks registers 0..7 on a
// dwell timer or push-button and shows one byte of the selected word on the LEDs.
module rf_led_scanner
    import rf_led_scanner_pkg::*;
#(
    parameter int DWELL_CYCLES = 50_000_000,
    parameter int CNT_W        = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [RF_IDX_W-1:0]  rd_reg,
    input  logic [RF_DATA_W-1:0] rd_data,
    input  logic [1:0]           sw,
    input  logic                 step_btn,
    input  logic                 auto_en,
    output logic [LED_W-1:0]     leds,
    output logic [RF_IDX_W-1:0]  cur_idx
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    logic [BYTE_SEL_W-1:0] sw_s;
    logic                  auto_s;
    logic                  step_pulse;

    sync_edge #(.W(3)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .edge_d (step_btn),
        .lvl_d  ({auto_en, sw}),
        .lvl_q  ({auto_s, sw_s}),
        .rise   (step_pulse)
    );

    scan_state_e           state;
    scan_state_e           state_nxt;
    logic [RF_IDX_W-1:0]   idx;
    logic [CNT_W-1:0]      dwell_cnt;
    logic                  step_pending;
    logic [RF_DATA_W-1:0]  cap_word;
    logic                  dwell_done;
    logic                  advance;

    always_ff @(posedge clk) begin
        if (rst) state <= SETTLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal written here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        advance    = 1'b0;
        dwell_done = auto_s && (dwell_cnt == DWELL_LAST);
        case (state)
            SETTLE: state_nxt = SHOW;
            SHOW: begin
                // A button press and a dwell expiry in the same cycle merge into one step.
                advance = step_pulse || step_pending || dwell_done;
                if (advance) state_nxt = SETTLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            dwell_cnt    <= '0;
            step_pending <= 1'b0;
            cap_word     <= '0;
            cur_idx      <= '0;
            leds         <= '0;
        end else begin
            leds <= {sw_s, select_byte(cap_word, sw_s)};
            if (state == SHOW) begin
                // Capture every SHOW cycle so register-file writes show up live.
                cap_word <= rd_data;
                cur_idx  <= idx;
                if (advance) begin
                    idx          <= idx + 1'b1;
                    dwell_cnt    <= '0;
                    step_pending <= 1'b0;
                end else if (auto_s) begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end else begin
                    dwell_cnt <= '0;
                end
            end else if (step_pulse) begin
                // The read address is still settling; remember the press for the next SHOW cycle.
                step_pending <= 1'b1;
            end
        end
    end

    assign rd_reg = idx;

endmodule

// File: tb/tb_rf_led_scanner.sv
// Scoreboard bench for rf_led_scanner: stimulus predicts each index advance,
// a monitor compares whenever cur_idx moves.
module tb_rf_led_scanner;

    localparam int DWELL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rd_reg;
    logic [31:0] rd_data;
    logic [1:0]  sw;
    logic        step_btn;
    logic        auto_en;
    logic [9:0]  leds;
    logic [2:0]  cur_idx;

    logic [31:0] rf [8];
    assign rd_data = rf[rd_reg];

    rf_led_scanner #(.DWELL_CYCLES(DWELL), .CNT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_reg   (rd_reg),
        .rd_data  (rd_data),
        .sw       (sw),
        .step_btn (step_btn),
        .auto_en  (auto_en),
        .leds     (leds),
        .cur_idx  (cur_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] idx;
        logic [9:0] leds;
        int         gap;   // cycles since previous cur_idx change; 0 = unchecked
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cycle    = 0;
    bit         mon_en   = 1'b0;
    logic [2:0] model_idx;
    logic [2:0] stim_last;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, got, want);
    endtask

    // Reference: LEDs show the lane tag and byte 'lane' of register k's current content.
    function automatic logic [9:0] model_leds(input logic [2:0] k, input logic [1:0] lane);
        logic [31:0] w;
        w = rf[k];
        return {lane, 8'(w >> (8 * lane))};
    endfunction

    task automatic push(input logic [2:0] k, input int g);
        exp_q.push_back('{idx: k, leds: model_leds(k, sw), gap: g});
    endtask

    task automatic push_raw(input logic [2:0] k, input logic [9:0] l, input int g);
        exp_q.push_back('{idx: k, leds: l, gap: g});
    endtask

    task automatic press(input int hold, input int gap);
        step_btn = 1'b1;
        repeat (hold) @(negedge clk);
        step_btn = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_change(input string name);
        bit seen;
        seen = 1'b0;
        repeat (60) begin
            if (!seen) begin
                @(negedge clk);
                if (cur_idx !== stim_last) seen = 1'b1;
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s: timeout, cur_idx stuck at %0d, want a change", name, cur_idx);
        end
        stim_last = cur_idx;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL %s: %0d expected advances never seen, want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: each cur_idx change is an output event; leds are compared a
    // cycle later, once the newly captured word has reached them.
    initial begin
        logic [2:0] prev;
        int         last;
        int         gap;
        exp_t       e;
        prev = '0;
        last = 0;
        forever begin
            @(negedge clk);
            cycle++;
            if (!mon_en) begin
                prev = cur_idx;
                last = cycle;
            end else if (cur_idx !== prev) begin
                gap  = cycle - last;
                prev = cur_idx;
                last = cycle;
                @(negedge clk);
                cycle++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_advance: cur_idx=%0d, want no change", prev);
                end else begin
                    e = exp_q.pop_front();
                    check("adv_idx", 32'(prev), 32'(e.idx));
                    check("adv_leds", 32'(leds), 32'(e.leds));
                    if (e.gap != 0) check("adv_gap", 32'(gap), 32'(e.gap));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        for (int k = 0; k < 8; k++) rf[k] = 32'hA0B0C000 + k;
        rst       = 1'b1;
        sw        = 2'd0;
        auto_en   = 1'b0;
        step_btn  = 1'b1;   // a press during reset must be lost
        model_idx = '0;
        stim_last = '0;

        repeat (3) @(negedge clk);
        check("rst_rd_reg", 32'(rd_reg), 32'd0);
        check("rst_cur_idx", 32'(cur_idx), 32'd0);
        check("rst_leds", 32'(leds), 32'd0);
        rst      = 1'b0;
        step_btn = 1'b0;

        ok = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (rd_reg !== 3'd0 || cur_idx !== 3'd0) ok = 1'b0;
        end
        check("idle_no_advance", 32'(ok), 32'd1);
        check("idle_leds", 32'(leds), 32'(model_leds(3'd0, 2'd0)));
        mon_en = 1'b1;

        // Manual: long holds still give one step per press.
        for (int p = 0; p < 3; p++) begin
            model_idx++;
            push(model_idx, 0);
            press(10, 4);
        end
        drain("manual_fixed");

        // Auto scan with lane 2 selected, through the 7 -> 0 wrap.
        sw        = 2'd2;
        auto_en   = 1'b1;
        stim_last = model_idx;
        model_idx++;
        push(model_idx, 0);
        wait_change("auto_first");
        for (int e = 0; e < 9; e++) begin
            model_idx++;
            push(model_idx, DWELL + 1);
            wait_change("auto_scan");
        end

        // Press whose synced pulse lands on the last dwell cycle: one step only.
        step_btn = 1'b1;
        model_idx++;
        push(model_idx, DWELL + 1);
        repeat (3) @(negedge clk);
        step_btn = 1'b0;
        wait_change("collision");

        // Press whose pulse lands in SETTLE: one extra step right after.
        model_idx++;
        push(model_idx, DWELL + 1);
        @(negedge clk);
        step_btn = 1'b1;
        model_idx++;
        push(model_idx, 2);
        @(negedge clk);
        step_btn = 1'b0;
        wait_change("dwell_before_pending");
        model_idx++;
        push(model_idx, DWELL + 1);
        wait_change("pending");
        wait_change("after_pending");
        auto_en = 1'b0;
        drain("auto");

        // Walk manually to register 5.
        sw = 2'd0;
        repeat (4) @(negedge clk);
        while (model_idx != 3'd5) begin
            model_idx++;
            push(model_idx, 0);
            press(2, 6);
        end
        drain("to_reg5");

        // Live update of the shown register, then lane change latency.
        repeat (3) @(negedge clk);
        rf[5] = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        check("live_leds", 32'(leds), 32'(model_leds(3'd5, 2'd0)));
        sw = 2'd3;
        repeat (2) @(negedge clk);
        check("sw_lat_old", 32'(leds), 32'(model_leds(3'd5, 2'd0)));
        @(negedge clk);
        check("sw_lat_new", 32'(leds), 32'(model_leds(3'd5, 2'd3)));

        // Randomised manual presses with random lanes and hold lengths.
        for (int p = 0; p < 5; p++) begin
            sw = 2'($urandom_range(0, 3));
            model_idx++;
            push(model_idx, 0);
            press(int'($urandom_range(1, 12)), int'($urandom_range(5, 10)));
        end
        drain("manual_random");

        // Auto scan up to register 6, then a one-cycle reset.
        sw        = 2'd2;
        auto_en   = 1'b1;
        stim_last = model_idx;
        do begin
            model_idx++;
            push(model_idx, 0);
            wait_change("to_six");
        end while (model_idx != 3'd6);
        push_raw(3'd0, 10'h000, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_rd_reg", 32'(rd_reg), 32'd0);
        check("midrst_cur_idx", 32'(cur_idx), 32'd0);
        check("midrst_leds", 32'(leds), 32'd0);
        model_idx = 3'd0;
        stim_last = 3'd0;
        model_idx++;
        push(model_idx, 8);
        for (int e = 0; e < 3; e++) begin
            wait_change("resume");
            model_idx++;
            push(model_idx, DWELL + 1);
        end
        wait_change("resume_last");
        drain("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
